// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and chunk-placement helper.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit position of the least significant bit of chunk k.
  function automatic int chunk_lsb(input int k, input int cw);
    return k * cw;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational CW-bit ripple add/subtract slice; also exposes the carry/borrow
// into its top bit so the final stage can derive signed overflow.
module addsub_slice
  import alu_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic          c_in,
  input  logic          sub,
  output logic [CW-1:0] r,
  output logic          c_out,
  output logic          c_msb_in
);

  // Bitwise ripple; w_c[i] is the carry (add) or borrow (sub) into bit i.
  always_comb begin
    logic [CW:0] w_c;
    w_c    = '0;
    w_c[0] = c_in;
    r      = '0;
    for (int i = 0; i < CW; i++) begin
      r[i] = x[i] ^ y[i] ^ w_c[i];
      if (sub == OP_SUB) begin
        w_c[i+1] = (~x[i] & y[i]) | (w_c[i] & ~(x[i] ^ y[i]));
      end else begin
        w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
      end
    end
    c_out    = w_c[CW];
    c_msb_in = w_c[CW-1];
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one CW-bit chunk per stage, globally stalled valid/ready.
// Optional ADDSUB_NZ_FLAGS_EN adds registered zero/negative flags.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cf,
`ifdef ADDSUB_NZ_FLAGS_EN
  output logic             out_zf,
  output logic             out_nf,
`endif
  output logic             out_of
);

  localparam int CW = WIDTH / STAGES;

  // Operands shift down one chunk per stage so each slice always reads bits [CW-1:0].
  typedef struct packed {
    logic             valid;
    logic             op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] res;
    logic             carry;
`ifdef ADDSUB_NZ_FLAGS_EN
    logic             zacc;
`endif
  } stage_t;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("pipelined_addsub: STAGES must be in 1..WIDTH and divide WIDTH");
  end

  logic             w_advance;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_cf;
  logic             r_out_of;
`ifdef ADDSUB_NZ_FLAGS_EN
  logic             r_out_zf;
  logic             r_out_nf;
`endif

  assign w_advance  = ~r_out_valid | out_ready;
  assign in_ready   = w_advance;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_cf     = r_out_cf;
  assign out_of     = r_out_of;
`ifdef ADDSUB_NZ_FLAGS_EN
  assign out_zf     = r_out_zf;
  assign out_nf     = r_out_nf;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           w_in;
    logic [CW-1:0]    w_r;
    logic             w_cout;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_res;

    if (k == 0) begin : g_first
      // Stage 0 takes its beat straight from the input port.
      always_comb begin
        w_in       = '0;
        w_in.valid = in_valid;
        w_in.op    = in_sub;
        w_in.x     = in_x;
        w_in.y     = in_y;
        w_in.res   = '0;
        w_in.carry = in_cin;
`ifdef ADDSUB_NZ_FLAGS_EN
        w_in.zacc  = 1'b1;
`endif
      end
    end else begin : g_chain
      assign w_in = g_stage[k-1].g_mid.r_st;
    end

    addsub_slice #(.CW(CW)) u_slice (
      .x        (w_in.x[CW-1:0]),
      .y        (w_in.y[CW-1:0]),
      .c_in     (w_in.carry),
      .sub      (w_in.op),
      .r        (w_r),
      .c_out    (w_cout),
      .c_msb_in (w_cmsb)
    );

    assign w_res = w_in.res | (WIDTH'(w_r) << chunk_lsb(k, CW));

    if (k < STAGES - 1) begin : g_mid
      stage_t r_st;
      logic   w_unused_msb;
      assign w_unused_msb = w_cmsb;

      // Intermediate stage register; holds everything while stalled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_st <= '0;
        end else if (w_advance) begin
          r_st.valid <= w_in.valid;
          r_st.op    <= w_in.op;
          r_st.x     <= w_in.x >> CW;
          r_st.y     <= w_in.y >> CW;
          r_st.res   <= w_res;
          r_st.carry <= w_cout;
`ifdef ADDSUB_NZ_FLAGS_EN
          r_st.zacc  <= w_in.zacc & (w_r == '0);
`endif
        end
      end
    end else begin : g_last
      if (STAGES > 1) begin : g_fold
        logic w_unused_hi;
        assign w_unused_hi = ^{w_in.x[WIDTH-1:CW], w_in.y[WIDTH-1:CW]};
      end

      // Output register; flags come from the MSB chunk's carries only.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_out_valid  <= 1'b0;
          r_out_result <= '0;
          r_out_cf     <= 1'b0;
          r_out_of     <= 1'b0;
`ifdef ADDSUB_NZ_FLAGS_EN
          r_out_zf     <= 1'b0;
          r_out_nf     <= 1'b0;
`endif
        end else if (w_advance) begin
          r_out_valid  <= w_in.valid;
          r_out_result <= w_res;
          r_out_cf     <= w_cout;
          r_out_of     <= w_cout ^ w_cmsb;
`ifdef ADDSUB_NZ_FLAGS_EN
          r_out_zf     <= w_in.zacc & (w_r == '0);
          r_out_nf     <= w_res[WIDTH-1];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed corner cases plus a randomized
// scoreboard against an arithmetic reference model.
module tb_pipelined_addsub;

  parameter int STAGES = 4;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cf;
    logic             of;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cf;
  logic             out_of;
`ifdef ADDSUB_NZ_FLAGS_EN
  logic             out_zf;
  logic             out_nf;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_cnt = 0;
  int   n_retired = 0;
  int   n_accepted = 0;
  int   last_ret_step = -1;
  exp_t last_ret;
  exp_t q[$];
  int   ret_log[$];

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sub     (in_sub),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_cin     (in_cin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cf     (out_cf),
`ifdef ADDSUB_NZ_FLAGS_EN
    .out_zf     (out_zf),
    .out_nf     (out_nf),
`endif
    .out_of     (out_of)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic sub, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y, input logic cin);
    exp_t   m;
    longint ux, uy, sx, sy, t, st;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sub) begin
      t  = ux - uy - longint'(cin);
      st = sx - sy - longint'(cin);
      m.cf = (ux < uy + longint'(cin));
    end else begin
      t  = ux + uy + longint'(cin);
      st = sx + sy + longint'(cin);
      m.cf = (t >= 64'sd4294967296);
    end
    m.res = t[WIDTH-1:0];
    m.of  = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    return m;
  endfunction

  // One clock cycle: drive, observe at negedge, advance past the next posedge.
  task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] x,
                      input logic [WIDTH-1:0] y, input logic c, input logic ordy);
    int   cur;
    exp_t e;
    cur       = step_cnt;
    in_valid  = v;
    in_sub    = s;
    in_x      = x;
    in_y      = y;
    in_cin    = c;
    out_ready = ordy;
    @(negedge clk);
    check("in_ready", in_ready, !out_valid || out_ready);
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        e = q[0];
        check("result", out_result, e.res);
        check("cf", out_cf, e.cf);
        check("of", out_of, e.of);
`ifdef ADDSUB_NZ_FLAGS_EN
        check("zf", out_zf, e.res == 0);
        check("nf", out_nf, e.res[WIDTH-1]);
`endif
        if (out_ready) begin
          void'(q.pop_front());
          n_retired++;
          last_ret_step = cur;
          last_ret = '{res: out_result, cf: out_cf, of: out_of};
          ret_log.push_back(cur);
        end
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(model(in_sub, in_x, in_y, in_cin));
      n_accepted++;
    end
    @(posedge clk);
    #1;
    step_cnt++;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, '0, '0, 1'b0, ordy);
  endtask

  task automatic rand_beat(input logic ordy);
    step(1'b1, 1'($urandom), $urandom, $urandom, 1'($urandom), ordy);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((q.size() > 0) && (guard < 1000)) begin
      idle(1'b1);
      guard++;
    end
    check(tag, q.size(), 0);
  endtask

  task automatic directed(input string tag, input logic sub, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic cin,
                          input logic [WIDTH-1:0] er, input logic ecf, input logic eof);
    int s0, r0, guard;
    s0 = step_cnt;
    r0 = n_retired;
    step(1'b1, sub, x, y, cin, 1'b1);
    guard = 0;
    while ((n_retired == r0) && (guard < 200)) begin
      idle(1'b1);
      guard++;
    end
    check({tag, "_latency"}, last_ret_step - s0, STAGES);
    check({tag, "_result"}, last_ret.res, er);
    check({tag, "_cf"}, last_ret.cf, ecf);
    check({tag, "_of"}, last_ret.of, eof);
  endtask

  initial begin
    int guard, r0, a0;
    rst = 1'b1; in_valid = 1'b0; in_sub = 1'b0; in_x = '0; in_y = '0; in_cin = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, '0);
    check("rst_out_cf", out_cf, 1'b0);
    check("rst_out_of", out_of, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
`ifdef ADDSUB_NZ_FLAGS_EN
    check("rst_out_zf", out_zf, 1'b0);
    check("rst_out_nf", out_nf, 1'b0);
`endif
    rst = 1'b0;
    idle(1'b1);

    directed("sub_5_7", 1'b1, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    directed("sub_min_1", 1'b1, 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    directed("add_max_1", 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("add_ripple", 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    directed("sub_borrow_in", 1'b1, 32'd3, 32'd3, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Eight back-to-back beats must retire on consecutive cycles.
    r0 = n_retired;
    repeat (8) rand_beat(1'b1);
    guard = 0;
    while ((n_retired - r0 < 8) && (guard < 200)) begin
      idle(1'b1);
      guard++;
    end
    check("b2b_count", n_retired - r0, 8);
    check("b2b_consecutive", ret_log[r0 + 7] - ret_log[r0], 7);

    // Fill until a result is waiting, then stall downstream for three cycles.
    guard = 0;
    while (!out_valid && (guard < 100)) begin
      rand_beat(1'b1);
      guard++;
    end
    check("stall_setup_valid", out_valid, 1'b1);
    a0 = n_accepted;
    repeat (3) rand_beat(1'b0);
    check("stall_no_accept", n_accepted - a0, 0);
    drain("stall_drain_empty");

    // Reset with three beats in flight drops them all.
    repeat (3) rand_beat(1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_result", out_result, '0);
    q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (STAGES + 3) idle(1'b1);
    directed("post_reset", 1'b0, 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0);

    // Random traffic with random backpressure.
    a0 = n_accepted;
    guard = 0;
    while ((n_accepted - a0 < 1000) && (guard < 20000)) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom,
           1'($urandom), 1'($urandom_range(0, 3) != 0));
      guard++;
    end
    check("rand_accepted", n_accepted - a0, 1000);
    drain("rand_drain_empty");
    repeat (STAGES + 2) idle(1'b1);
    check("final_out_valid", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
